// File: rtl/divisor_seq_param.sv
// Sequential restoring divider (signed/unsigned), one quotient bit per clock, busy/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase and finishes one cycle after accept.
module divisor_seq_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] orig_q;
    logic             neg_quo_q, neg_rem_q, zero_q, ovf_q;
    logic             accept;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q_fix, r_fix;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && (v < 0))
            return negate(v);
        return v;
    endfunction

    assign accept = (state_q == S_IDLE) && start;
    assign busy   = (state_q != S_IDLE);

    // Shifted remainder is always below twice the divisor, so bit WIDTH of the difference is the borrow.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0)
                        state_d = S_FIX;
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        q_fix = neg_quo_q ? negate(dvd_q) : dvd_q;
        r_fix = neg_rem_q ? negate(rem_q) : rem_q;
        if (zero_q) begin
            q_fix = '1;
            r_fix = orig_q;
        end else if (ovf_q) begin
            q_fix = MIN_VAL;
            r_fix = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            done        <= 1'b0;
            quociente   <= '0;
            resto       <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= (state_q == S_FIX);
            if (state_q == S_FIX) begin
                quociente   <= q_fix;
                resto       <= r_fix;
                div_by_zero <= zero_q;
                overflow    <= ovf_q;
            end
        end
    end

    // Operand capture and iteration datapath; quotient bits shift into dvd_q as dividend bits leave.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q     <= magnitude(dividendo, signed_mode);
            dsr_q     <= magnitude(divisor, signed_mode);
            rem_q     <= '0;
            orig_q    <= dividendo;
            neg_quo_q <= signed_mode && (dividendo[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= signed_mode && dividendo[WIDTH-1];
            zero_q    <= (divisor == '0);
            ovf_q     <= signed_mode && (dividendo == MIN_VAL) && (divisor == '1);
        end else if (state_q == S_RUN) begin
            rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

endmodule

// File: tb/tb_divisor_seq_param.sv
// Bench for divisor_seq_param: WIDTH=4 and WIDTH=8 instances, directed table plus random ops vs. an arithmetic model.
module tb_divisor_seq_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       st;
    logic       smode;
    logic [7:0] a8, b8;
    int         w_sel;

    logic       start4, start8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;
    logic       dz4, ov4, busy4, done4, dz8, ov8, busy8, done8;
    logic [7:0] q_o, r_o;
    logic       dz_o, ov_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start4 = st && (w_sel == 4);
    assign start8 = st && (w_sel == 8);

    divisor_seq_param #(.WIDTH(4)) u_div4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(smode),
        .dividendo(a8[3:0]), .divisor(b8[3:0]),
        .quociente(q4), .resto(r4), .div_by_zero(dz4), .overflow(ov4),
        .busy(busy4), .done(done4)
    );

    divisor_seq_param #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(smode),
        .dividendo(a8), .divisor(b8),
        .quociente(q8), .resto(r8), .div_by_zero(dz8), .overflow(ov8),
        .busy(busy8), .done(done8)
    );

    always_comb begin
        q_o    = (w_sel == 8) ? q8    : {4'b0, q4};
        r_o    = (w_sel == 8) ? r8    : {4'b0, r4};
        dz_o   = (w_sel == 8) ? dz8   : dz4;
        ov_o   = (w_sel == 8) ? ov8   : ov4;
        busy_o = (w_sel == 8) ? busy8 : busy4;
        done_o = (w_sel == 8) ? done8 : done4;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with SystemVerilog's truncating / and % for the signed case.
    function automatic void model(input int w, input bit s, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int mask, ua, ub, sa, sb;
        mask = (1 << w) - 1;
        ua = int'(a) & mask;
        ub = int'(b) & mask;
        dz = 1'b0;
        ov = 1'b0;
        if (ub == 0) begin
            q = 8'(mask); r = 8'(ua); dz = 1'b1;
        end else if (s && ua == (1 << (w - 1)) && ub == mask) begin
            q = 8'(ua); r = 8'h00; ov = 1'b1;
        end else if (s) begin
            sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
            sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
            q = 8'((sa / sb) & mask);
            r = 8'((sa % sb) & mask);
        end else begin
            q = 8'(ua / ub);
            r = 8'(ua % ub);
        end
    endfunction

    // Issues one request from between clock edges and returns #1 after the done edge.
    task automatic op(input int w, input bit s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz, input logic eov,
                      input int poke_k, input string tag);
        int  lat, k, busy_cnt;
        bit  got;
        w_sel = w; smode = s; a8 = a; b8 = b; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        lat = w + 1;
`ifdef DIV_ZERO_FAST_EN
        if ((int'(b) & ((1 << w) - 1)) == 0) lat = 1;
`endif
        k = 0; busy_cnt = 0; got = 0;
        while (k <= w + 4) begin
            if (done_o) begin
                got = 1;
                break;
            end
            if (busy_o) busy_cnt++;
            if (k == poke_k) begin
                st = 1'b1; a8 = ~a; b8 = 8'h01; smode = ~s;
            end else if (k == poke_k + 1) begin
                st = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        st = 1'b0;
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat));
        check({tag, " busy_in_done"}, 32'(busy_o), 32'd0);
        check({tag, " quociente"}, 32'(q_o), 32'(eq));
        check({tag, " resto"}, 32'(r_o), 32'(er));
        check({tag, " div_by_zero"}, 32'(dz_o), 32'(edz));
        check({tag, " overflow"}, 32'(ov_o), 32'(eov));
    endtask

    typedef struct {
        int         w;
        bit         s;
        logic [7:0] a, b, q, r;
        logic       dz, ov;
        int         poke;
        string      tag;
    } vec_t;

    initial begin
        vec_t       vecs[10];
        logic [7:0] eq, er, ra, rb;
        logic       edz, eov;
        bit         rs;
        int         w, dones;

        vecs[0] = '{4, 0, 8'd13,  8'd3,   8'd4,   8'd1,   0, 0, -1, "u4_13_3"};
        vecs[1] = '{4, 1, 8'h9,   8'h2,   8'hD,   8'hF,   0, 0, -1, "s4_m7_2"};
        vecs[2] = '{4, 1, 8'h7,   8'hE,   8'hD,   8'h1,   0, 0, -1, "s4_7_m2"};
        vecs[3] = '{4, 0, 8'h9,   8'h0,   8'hF,   8'h9,   1, 0, -1, "u4_div0"};
        vecs[4] = '{4, 1, 8'h8,   8'hF,   8'h8,   8'h0,   0, 1, -1, "s4_ovf"};
        vecs[5] = '{4, 0, 8'h8,   8'hF,   8'h0,   8'h8,   0, 0, -1, "u4_8_15"};
        vecs[6] = '{8, 0, 8'd200, 8'd7,   8'd28,  8'd4,   0, 0,  2, "u8_200_7_poke"};
        vecs[7] = '{8, 0, 8'd255, 8'd16,  8'd15,  8'd15,  0, 0, -1, "u8_b2b_255_16"};
        vecs[8] = '{8, 1, 8'h80,  8'hFF,  8'h80,  8'h00,  0, 1, -1, "s8_ovf"};
        vecs[9] = '{4, 1, 8'h9,   8'h0,   8'hF,   8'h9,   1, 0, -1, "s4_div0"};

        rst = 1'b1; st = 1'b0; smode = 1'b0; a8 = '0; b8 = '0; w_sel = 4;
        #2;
        check("reset quociente", 32'(q4), 32'd0);
        check("reset resto", 32'(r4), 32'd0);
        check("reset flags", {30'd0, dz4, ov4}, 32'd0);
        check("reset busy_done", {30'd0, busy4, done4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Entries run back to back: each start is raised during the previous done cycle.
        for (int i = 0; i < 10; i++)
            op(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
               vecs[i].dz, vecs[i].ov, vecs[i].poke, vecs[i].tag);

        @(posedge clk); #1;
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("hold quociente", 32'(q_o), 32'h0F);
        check("hold resto", 32'(r_o), 32'h09);
        check("hold div_by_zero", 32'(dz_o), 32'd1);

        // Asynchronous reset in the middle of an operation.
        w_sel = 4; smode = 1'b0; a8 = 8'd13; b8 = 8'd3; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst quociente", 32'(q4), 32'd0);
        check("midrst resto", 32'(r4), 32'd0);
        check("midrst flags", {30'd0, dz4, ov4}, 32'd0);
        check("midrst busy", 32'(busy4), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        check("midrst no_done", 32'(dones), 32'd0);
        op(4, 0, 8'd13, 8'd3, 8'd4, 8'd1, 0, 0, -1, "after_rst");

        for (int i = 0; i < 80; i++) begin
            w  = (i % 2 == 0) ? 4 : 8;
            rs = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 8'h00;
                1: begin
                    rs = 1'b1;
                    ra = (w == 4) ? 8'h08 : 8'h80;
                    rb = 8'hFF;
                end
                default: ;
            endcase
            model(w, rs, ra, rb, eq, er, edz, eov);
            op(w, rs, ra, rb, eq, er, edz, eov, -1, "rand");
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
